// File: rtl/channel_merger_if.sv
// channel_merger_if: bundles the three per-channel valid/ready inputs and the
// serialized valid/ready output of the RGB channel merger.
//
//   R/G/B_data_in, R/G/B_valid_in : channel bytes from the producers
//   R/G/B_ready_out               : holding register can accept
//   data_out, valid_out           : serialized byte stream (R, G, B order)
//   ready_in                      : downstream accepts data_out
//   channel_out                   : 0=R, 1=G, 2=B
//   last_out                      : high with the B byte of each pixel
//
// Modports: slave = merger side, master = producer/consumer side.
interface channel_merger_if #(
  parameter int bitwidth = 8
);
  logic [bitwidth-1:0] R_data_in;
  logic                R_valid_in;
  logic                R_ready_out;
  logic [bitwidth-1:0] G_data_in;
  logic                G_valid_in;
  logic                G_ready_out;
  logic [bitwidth-1:0] B_data_in;
  logic                B_valid_in;
  logic                B_ready_out;
  logic [bitwidth-1:0] data_out;
  logic                valid_out;
  logic                ready_in;
  logic [1:0]          channel_out;
  logic                last_out;

  modport slave (
    input  R_data_in, R_valid_in, G_data_in, G_valid_in, B_data_in, B_valid_in,
    input  ready_in,
    output R_ready_out, G_ready_out, B_ready_out,
    output data_out, valid_out, channel_out, last_out
  );

  modport master (
    output R_data_in, R_valid_in, G_data_in, G_valid_in, B_data_in, B_valid_in,
    output ready_in,
    input  R_ready_out, G_ready_out, B_ready_out,
    input  data_out, valid_out, channel_out, last_out
  );
endinterface

// File: rtl/channel_merger.sv
// channel_merger: collects one byte per colour channel on three independent
// valid/ready inputs and, once all three are held, emits the pixel as a
// serial R, G, B byte stream on a single valid/ready output.
//
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous, active-high reset
//   bus         : channel_merger_if.slave (channel inputs, serialized output)
//   pixel_count : 32-bit count of completed pixels (only with
//                 CHANNEL_MERGER_PIXEL_COUNT_EN defined)
//
// Optional feature macro: CHANNEL_MERGER_PIXEL_COUNT_EN
module channel_merger #(
  parameter int bitwidth = 8
) (
  input  logic              clock,
  input  logic              reset,
  channel_merger_if.slave   bus
`ifdef CHANNEL_MERGER_PIXEL_COUNT_EN
  ,
  output logic [31:0]       pixel_count
`endif
);

  typedef enum logic [1:0] {IDLE, EMIT_R, EMIT_G, EMIT_B} state_t;

  state_t state_q, state_d;

  logic                r_vld_p0, g_vld_p0, b_vld_p0;
  logic [bitwidth-1:0] r_hold_p0, g_hold_p0, b_hold_p0;
  logic [bitwidth-1:0] pr_p1, pg_p1, pb_p1;
  logic [bitwidth-1:0] pr_d, pg_d, pb_d;

  logic                all_full;
  logic                xfer;
  logic                load;

  logic [bitwidth-1:0] data_d;
  logic [1:0]          chan_d;
  logic                last_d;
  logic                vld_d;

  assign bus.R_ready_out = !r_vld_p0;
  assign bus.G_ready_out = !g_vld_p0;
  assign bus.B_ready_out = !b_vld_p0;

  assign all_full = r_vld_p0 && g_vld_p0 && b_vld_p0;
  assign xfer     = bus.valid_out && bus.ready_in;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (all_full) begin
          load    = 1'b1;
          state_d = EMIT_R;
        end
      end
      EMIT_R: if (xfer) state_d = EMIT_G;
      EMIT_G: if (xfer) state_d = EMIT_B;
      EMIT_B: begin
        if (xfer) begin
          // Back-to-back pixels: reload straight into EMIT_R with no bubble.
          if (all_full) begin
            load    = 1'b1;
            state_d = EMIT_R;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the byte being loaded
  // this edge must be visible to the output mux before it lands in pr/pg/pb.
  assign pr_d = load ? r_hold_p0 : pr_p1;
  assign pg_d = load ? g_hold_p0 : pg_p1;
  assign pb_d = load ? b_hold_p0 : pb_p1;

  always_comb begin
    vld_d  = 1'b0;
    data_d = '0;
    chan_d = 2'd0;
    last_d = 1'b0;
    case (state_d)
      EMIT_R: begin
        vld_d  = 1'b1;
        data_d = pr_d;
        chan_d = 2'd0;
      end
      EMIT_G: begin
        vld_d  = 1'b1;
        data_d = pg_d;
        chan_d = 2'd1;
      end
      EMIT_B: begin
        vld_d  = 1'b1;
        data_d = pb_d;
        chan_d = 2'd2;
        last_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- stage p0: per-channel holding registers ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      g_vld_p0 <= 1'b0;
      b_vld_p0 <= 1'b0;
    end else begin
      // A full flag can only be cleared by a load while ready is low, so a
      // capture and a load never hit the same channel on one edge.
      if (load)                               r_vld_p0 <= 1'b0;
      else if (bus.R_valid_in && !r_vld_p0)   r_vld_p0 <= 1'b1;
      if (load)                               g_vld_p0 <= 1'b0;
      else if (bus.G_valid_in && !g_vld_p0)   g_vld_p0 <= 1'b1;
      if (load)                               b_vld_p0 <= 1'b0;
      else if (bus.B_valid_in && !b_vld_p0)   b_vld_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (bus.R_valid_in && !r_vld_p0) r_hold_p0 <= bus.R_data_in;
    if (bus.G_valid_in && !g_vld_p0) g_hold_p0 <= bus.G_data_in;
    if (bus.B_valid_in && !b_vld_p0) b_hold_p0 <= bus.B_data_in;
  end

  // ---- stage p1: pixel register ----
  always_ff @(posedge clock) begin
    pr_p1 <= pr_d;
    pg_p1 <= pg_d;
    pb_p1 <= pb_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- stage p2: serialized output registers ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.valid_out   <= 1'b0;
      bus.data_out    <= '0;
      bus.channel_out <= 2'd0;
      bus.last_out    <= 1'b0;
    end else begin
      bus.valid_out   <= vld_d;
      bus.data_out    <= data_d;
      bus.channel_out <= chan_d;
      bus.last_out    <= last_d;
    end
  end

`ifdef CHANNEL_MERGER_PIXEL_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          pixel_count <= '0;
    else if (xfer && state_q == EMIT_B) pixel_count <= pixel_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_channel_merger.sv
// Table-driven bench for channel_merger: each row gives the inputs for one
// clock cycle and the outputs expected just after that cycle's rising edge.
module tb_channel_merger;

  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef CHANNEL_MERGER_PIXEL_COUNT_EN
  logic [31:0] pixel_count;
`endif

  channel_merger_if #(.bitwidth(8)) bus ();

  channel_merger #(.bitwidth(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave)
`ifdef CHANNEL_MERGER_PIXEL_COUNT_EN
    ,
    .pixel_count (pixel_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] vm;     // {R,G,B} valid
    logic [7:0] r, g, b;
    logic       rdy;    // ready_in
    logic       ev;     // expected valid_out
    logic [7:0] ed;     // expected data_out
    logic [1:0] ec;     // expected channel_out
    logic       el;     // expected last_out
    logic [2:0] er;     // expected {R,G,B}_ready_out
  } vec_t;

  vec_t tbl[$];
  int   seg[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic [2:0] vm, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic rdy, input logic ev,
                              input logic [7:0] ed, input logic [1:0] ec, input logic el,
                              input logic [2:0] er);
    vec_t v;
    v.vm = vm; v.r = r; v.g = g; v.b = b; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.el = el; v.er = er;
    return v;
  endfunction

  task automatic drive_idle();
    bus.R_valid_in = 1'b0; bus.G_valid_in = 1'b0; bus.B_valid_in = 1'b0;
    bus.R_data_in  = 8'h00; bus.G_data_in = 8'h00; bus.B_data_in = 8'h00;
    bus.ready_in   = 1'b1;
  endtask

  task automatic check_out(input string tag, input int idx, input logic ev, input logic [7:0] ed,
                           input logic [1:0] ec, input logic el, input logic [2:0] er);
    logic [15:0] act, exp;
    act = {bus.valid_out, bus.data_out, bus.channel_out, bus.last_out,
           bus.R_ready_out, bus.G_ready_out, bus.B_ready_out};
    exp = {ev, ed, ec, el, er};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got vld=%0b data=%02h ch=%0d last=%0b rdy=%03b, want vld=%0b data=%02h ch=%0d last=%0b rdy=%03b",
               tag, idx, act[15], act[14:7], act[6:5], act[4], act[2:0], ev, ed, ec, el, er);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    bus.R_valid_in = v.vm[2]; bus.R_data_in = v.r;
    bus.G_valid_in = v.vm[1]; bus.G_data_in = v.g;
    bus.B_valid_in = v.vm[0]; bus.B_data_in = v.b;
    bus.ready_in   = v.rdy;
    @(posedge clock);
    #1;
    check_out("vec", idx, v.ev, v.ed, v.ec, v.el, v.er);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply(tbl[i], i);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    drive_idle();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Segment 0: idle after reset release, 10 cycles.
    for (int i = 0; i < 10; i++) tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111));
    seg.push_back(tbl.size());
    // Segment 1: all three channels in one cycle.
    tbl.push_back(mk(3'b111, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h11, 2'd0, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h22, 2'd1, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111));
    seg.push_back(tbl.size());
    // Segment 2: staggered B@0, R@4, G@9.
    tbl.push_back(mk(3'b001, 8'h00, 8'h00, 8'hB0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b110));
    for (int i = 1; i < 4; i++) tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b110));
    tbl.push_back(mk(3'b100, 8'hA0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b010));
    for (int i = 5; i < 9; i++) tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b010));
    tbl.push_back(mk(3'b010, 8'h00, 8'hC0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hC0, 2'd1, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hB0, 2'd2, 1'b1, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111));
    seg.push_back(tbl.size());
    // Segment 3: four pixels streamed, producers advance only after a handshake.
    tbl.push_back(mk(3'b111, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000));
    tbl.push_back(mk(3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 1'b1, 8'h01, 2'd0, 1'b0, 3'b111));
    tbl.push_back(mk(3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 1'b1, 8'h02, 2'd1, 1'b0, 3'b000));
    tbl.push_back(mk(3'b111, 8'h07, 8'h08, 8'h09, 1'b1, 1'b1, 8'h03, 2'd2, 1'b1, 3'b000));
    tbl.push_back(mk(3'b111, 8'h07, 8'h08, 8'h09, 1'b1, 1'b1, 8'h04, 2'd0, 1'b0, 3'b111));
    tbl.push_back(mk(3'b111, 8'h07, 8'h08, 8'h09, 1'b1, 1'b1, 8'h05, 2'd1, 1'b0, 3'b000));
    tbl.push_back(mk(3'b111, 8'h0A, 8'h0B, 8'h0C, 1'b1, 1'b1, 8'h06, 2'd2, 1'b1, 3'b000));
    tbl.push_back(mk(3'b111, 8'h0A, 8'h0B, 8'h0C, 1'b1, 1'b1, 8'h07, 2'd0, 1'b0, 3'b111));
    tbl.push_back(mk(3'b111, 8'h0A, 8'h0B, 8'h0C, 1'b1, 1'b1, 8'h08, 2'd1, 1'b0, 3'b000));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h09, 2'd2, 1'b1, 3'b000));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h0A, 2'd0, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h0B, 2'd1, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h0C, 2'd2, 1'b1, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111));
    seg.push_back(tbl.size());
    // Segment 4: ready_in low for 5 cycles while the G byte 0xA5 is presented.
    tbl.push_back(mk(3'b111, 8'h5A, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A, 2'd0, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA5, 2'd1, 1'b0, 3'b111));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA5, 2'd1, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h3C, 2'd2, 1'b1, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111));
    seg.push_back(tbl.size());
    // Segment 5: reach EMIT_G with all holding registers refilled.
    tbl.push_back(mk(3'b111, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000));
    tbl.push_back(mk(3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 1'b1, 8'h01, 2'd0, 1'b0, 3'b111));
    tbl.push_back(mk(3'b111, 8'h04, 8'h05, 8'h06, 1'b1, 1'b1, 8'h02, 2'd1, 1'b0, 3'b000));
    seg.push_back(tbl.size());
    // Segment 6: fresh pixel after the mid-pixel reset.
    tbl.push_back(mk(3'b111, 8'h07, 8'h08, 8'h09, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h07, 2'd0, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h08, 2'd1, 1'b0, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h09, 2'd2, 1'b1, 3'b111));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111));
    seg.push_back(tbl.size());

    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check_out("in_reset", 0, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111);
    @(negedge clock);
    reset = 1'b0;

    run_range(0, seg[0]);
    run_range(seg[0], seg[1]);
    run_range(seg[1], seg[2]);

    pulse_reset();
    run_range(seg[2], seg[3]);
`ifdef CHANNEL_MERGER_PIXEL_COUNT_EN
    n_vec++;
    if (pixel_count !== 32'd4) begin
      n_miss++;
      $display("FAIL pixel_count_stream: got %0d, want 4", pixel_count);
    end
`endif

    run_range(seg[3], seg[4]);

    run_range(seg[4], seg[5]);
    // Asynchronous reset mid-cycle while emitting G with holding regs full.
    @(negedge clock);
    drive_idle();
    reset = 1'b1;
    #1;
    check_out("mid_reset", 0, 1'b0, 8'h00, 2'd0, 1'b0, 3'b111);
`ifdef CHANNEL_MERGER_PIXEL_COUNT_EN
    n_vec++;
    if (pixel_count !== 32'd0) begin
      n_miss++;
      $display("FAIL pixel_count_reset: got %0d, want 0", pixel_count);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
    run_range(seg[5], seg[6]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/channel_merger.md
Name: channel_merger

Overview:
- Inverse of the RGB channel splitter. Accepts one byte per colour channel (R, G, B) on three independent valid/ready inputs.
- Once all three channels hold a byte, emits the pixel as a serial byte stream in the order R, G, B on a single valid/ready output.
- Sits upstream of any block that consumes interleaved RGB bytes, e.g. the stream feeding the splitter or an external frame sink.

Parameters:
bitwidth, 8, width of each channel byte and of data_out

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
R_data_in  input  bitwidth  red channel byte
R_valid_in  input  1  red byte valid
R_ready_out  output  1  red holding register can accept
G_data_in  input  bitwidth  green channel byte
G_valid_in  input  1  green byte valid
G_ready_out  output  1  green holding register can accept
B_data_in  input  bitwidth  blue channel byte
B_valid_in  input  1  blue byte valid
B_ready_out  output  1  blue holding register can accept
data_out  output  bitwidth  serialized byte
valid_out  output  1  data_out valid
ready_in  input  1  downstream accepts data_out
channel_out  output  2  tag for data_out: 0=R, 1=G, 2=B; 3 never driven
last_out  output  1  high with the B byte (end of pixel)

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Reset values:
  - all holding-full flags 0; FSM in IDLE
  - valid_out=0, data_out=0, channel_out=0, last_out=0
  - X_ready_out=1 (ready is !X_full)
- Reset asserted mid-pixel discards both the partial pixel and any held bytes.
- Per-channel holding register (X = R, G, B):
  - X_ready_out = !X_full.
  - Capture on a rising edge with X_valid_in && X_ready_out; X_full is set.
  - Channels fill independently and in any order.
- Pixel register: three bytes pr, pg, pb.
- FSM states: IDLE, EMIT_R, EMIT_G, EMIT_B.
- IDLE:
  - If R_full && G_full && B_full: copy the three holding registers into pr/pg/pb, clear all three full flags, go to EMIT_R.
  - Otherwise stay in IDLE.
- Output registers are driven from the next state:
  - EMIT_R: data_out=pr, channel_out=0, last_out=0
  - EMIT_G: data_out=pg, channel_out=1, last_out=0
  - EMIT_B: data_out=pb, channel_out=2, last_out=1
  - valid_out=1 in every EMIT state.
- Transfer = valid_out && ready_in.
  - EMIT_R -> EMIT_G and EMIT_G -> EMIT_B on transfer.
  - EMIT_B on transfer: if all three full, load the next pixel and go directly to EMIT_R (no bubble); otherwise go to IDLE with valid_out=0.
- Backpressure: while valid_out && !ready_in, data_out, channel_out and last_out hold stable. The state does not advance.
- Latency: third channel captured at edge N -> R byte valid after edge N+1. Steady-state throughput is 1 byte/cycle, i.e. 3 cycles per pixel.
- Holding registers refill while the pixel register is being emitted. A load clears the full flags in the same edge. Capture and load never coincide on one channel, because ready is low while full.
- No byte is dropped or duplicated. Output order is strictly R, G, B per pixel, and pixels leave in arrival order.

Optional Feature:
- Macro CHANNEL_MERGER_PIXEL_COUNT_EN.
- Defined:
  - Adds output pixel_count (32 bits, reset 0).
  - Increments by 1 on each transfer in EMIT_B and wraps from 2^32-1 to 0.
  - Reset clears it asynchronously.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release, all inputs idle -> valid_out=0, data_out=0, all X_ready_out=1; stays IDLE for 10 cycles.
- R=0x11, G=0x22, B=0x33 valid in one cycle, ready_in=1 -> data_out 0x11/0x22/0x33 on three consecutive cycles; channel_out 0,1,2; last_out only on 0x33; valid_out drops after.
- Channels staggered (B at cycle 0, R at cycle 4, G at cycle 9) -> no output before cycle 10; then R, G, B bytes in order; R_ready_out/B_ready_out low while waiting.
- 4 pixels streamed with inputs always valid, ready_in=1 -> 12 back-to-back bytes with no bubble. With CHANNEL_MERGER_PIXEL_COUNT_EN, pixel_count=4.
- ready_in held low 5 cycles during EMIT_G with data 0xA5 -> data_out=0xA5, channel_out=1 stable all 5 cycles; 0xA5 transferred once when ready_in rises.
- reset pulsed during EMIT_G with all holding registers full -> outputs return to reset values immediately; the next pixel supplied after reset is emitted complete and in order.
